nios2_cpu_debug_scan_master: RTL and testbench

Host-side initiator for the Nios II on-chip debug slave's virtual-JTAG port. It accepts a command consisting of an IR value and a data word, then generates the JTAG-side sequence that the debug slave's TCK-domain logic expects: IR update, DR capture, SR_WIDTH shift periods, DR update and run-test-idle. The block returns the word shifted out of the slave. It sits in place of the sld_virtual_jtag_basic hub for in-system and simulation-driven debug access, clocked from the system clock.

---
 rtl/nios2_cpu_debug_scan_master_if.sv | 30 +++
 rtl/nios2_cpu_debug_scan_master.sv | 177 +++++++++++++++++
 tb/tb_nios2_cpu_debug_scan_master.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_cpu_debug_scan_master_if.sv
// Command/response channel between a debug host and the scan master.
//   cmd_valid/cmd_ready : command handshake, accepted when both are high
//   cmd_ir              : virtual IR value for the scan
//   cmd_data            : word shifted into the debug slave, LSB first
//   rsp_valid           : one-cycle completion pulse
//   rsp_data            : word shifted out of the debug slave
//   busy                : scan in progress (inverse of cmd_ready)
// The host side uses the master modport, the scan engine the slave modport.
interface nios2_cpu_debug_scan_master_if #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [SR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic [SR_WIDTH-1:0] rsp_data;
    logic                busy;

    modport master (
        output cmd_valid, cmd_ir, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/nios2_cpu_debug_scan_master.sv
// Host-side initiator for the Nios II debug slave's virtual-JTAG port.
// Takes an IR value and a data word, then walks the slave through
// UIR -> CDR -> SDR (SR_WIDTH periods) -> UDR -> RTI on a TCK derived from
// clk, and returns the word shifted out of the slave.
// Ports:
//   clk, reset_n   : system clock; asynchronous active-low reset
//   host           : command/response channel (slave modport)
//   vji_tck        : generated TCK, low while idle
//   vji_tdi/tdo    : serial data to/from the debug slave
//   vji_ir_in      : virtual IR value for the current scan
//   vji_uir..rti   : one-hot virtual-state strobes
module nios2_cpu_debug_scan_master #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    nios2_cpu_debug_scan_master_if.slave   host,
    output logic                           vji_tck,
    output logic                           vji_tdi,
    input  logic                           vji_tdo,
    output logic [IR_WIDTH-1:0]            vji_ir_in,
    output logic                           vji_uir,
    output logic                           vji_cdr,
    output logic                           vji_sdr,
    output logic                           vji_udr,
    output logic                           vji_rti
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI
    } state_t;

    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BIT_W = $clog2(SR_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SR_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    state_t              state_reg;
    logic [DIV_W-1:0]    div_cnt_reg;
    logic [BIT_W-1:0]    bit_cnt_reg;
    logic [SR_WIDTH-1:0] tx_sr_reg;
    logic [SR_WIDTH-1:0] rx_sr_reg;
    logic [SR_WIDTH-1:0] rsp_data_reg;
    logic                cmd_ready_reg;
    logic                rsp_valid_reg;
    logic                tck_reg;
    logic                tdi_reg;
    logic [IR_WIDTH-1:0] ir_in_reg;
    logic                uir_reg;
    logic                cdr_reg;
    logic                sdr_reg;
    logic                udr_reg;
    logic                rti_reg;

    logic                half_end;
    logic                tck_rise;
    logic                period_end;
    logic [SR_WIDTH-1:0] tx_next;

    // A half-period ends when the divider wraps; the edge that ends the
    // high half is a period boundary (tck falls there).
    assign half_end   = (div_cnt_reg == DIV_LAST);
    assign tck_rise   = half_end && !tck_reg;
    assign period_end = half_end && tck_reg;
    assign tx_next    = tx_sr_reg >> 1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            div_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            tx_sr_reg     <= '0;
            rx_sr_reg     <= '0;
            rsp_data_reg  <= '0;
            cmd_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            tck_reg       <= 1'b0;
            tdi_reg       <= 1'b0;
            ir_in_reg     <= '0;
            uir_reg       <= 1'b0;
            cdr_reg       <= 1'b0;
            sdr_reg       <= 1'b0;
            udr_reg       <= 1'b0;
            rti_reg       <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (host.cmd_valid) begin
                    state_reg     <= ST_UIR;
                    ir_in_reg     <= host.cmd_ir;
                    tx_sr_reg     <= host.cmd_data;
                    rx_sr_reg     <= '0;
                    div_cnt_reg   <= '0;
                    tck_reg       <= 1'b0;
                    uir_reg       <= 1'b1;
                    cmd_ready_reg <= 1'b0;
                end
            end else begin
                if (half_end) begin
                    div_cnt_reg <= '0;
                    tck_reg     <= ~tck_reg;
                end else begin
                    div_cnt_reg <= div_cnt_reg + DIV_ONE;
                end

                // Sample TDO on the edge that raises TCK, LSB-first into the top.
                if (tck_rise && state_reg == ST_SDR) begin
                    rx_sr_reg <= {vji_tdo, rx_sr_reg[SR_WIDTH-1:1]};
                end

                if (period_end) begin
                    case (state_reg)
                        ST_UIR: begin
                            state_reg <= ST_CDR;
                            uir_reg   <= 1'b0;
                            cdr_reg   <= 1'b1;
                        end
                        ST_CDR: begin
                            state_reg   <= ST_SDR;
                            cdr_reg     <= 1'b0;
                            sdr_reg     <= 1'b1;
                            bit_cnt_reg <= '0;
                            tdi_reg     <= tx_sr_reg[0];
                        end
                        ST_SDR: begin
                            tx_sr_reg <= tx_next;
                            if (bit_cnt_reg == BIT_LAST) begin
                                state_reg <= ST_UDR;
                                sdr_reg   <= 1'b0;
                                udr_reg   <= 1'b1;
                                tdi_reg   <= 1'b0;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + BIT_ONE;
                                tdi_reg     <= tx_next[0];
                            end
                        end
                        ST_UDR: begin
                            state_reg <= ST_RTI;
                            udr_reg   <= 1'b0;
                            rti_reg   <= 1'b1;
                        end
                        ST_RTI: begin
                            state_reg     <= ST_IDLE;
                            rti_reg       <= 1'b0;
                            ir_in_reg     <= '0;
                            rsp_data_reg  <= rx_sr_reg;
                            rsp_valid_reg <= 1'b1;
                            cmd_ready_reg <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign host.cmd_ready = cmd_ready_reg;
    assign host.busy      = ~cmd_ready_reg;
    assign host.rsp_valid = rsp_valid_reg;
    assign host.rsp_data  = rsp_data_reg;
    assign vji_tck        = tck_reg;
    assign vji_tdi        = tdi_reg;
    assign vji_ir_in      = ir_in_reg;
    assign vji_uir        = uir_reg;
    assign vji_cdr        = cdr_reg;
    assign vji_sdr        = sdr_reg;
    assign vji_udr        = udr_reg;
    assign vji_rti        = rti_reg;
endmodule

// File: tb/tb_nios2_cpu_debug_scan_master.sv
module tb_nios2_cpu_debug_scan_master;
    localparam int SRW = 38;
    localparam int IRW = 2;
    localparam int SCAN_CYC      = 2 * 2 * (SRW + 4);
    localparam int SCAN_CYC_FAST = 2 * 1 * (SRW + 4);

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n = 1'b0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- main DUT (TCK_DIV=2) ----------------
    nios2_cpu_debug_scan_master_if #(.SR_WIDTH(SRW), .IR_WIDTH(IRW)) bus();
    logic           vji_tck, vji_tdi, vji_tdo;
    logic [IRW-1:0] vji_ir_in;
    logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    nios2_cpu_debug_scan_master #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .TCK_DIV(2)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .host      (bus),
        .vji_tck   (vji_tck),
        .vji_tdi   (vji_tdi),
        .vji_tdo   (vji_tdo),
        .vji_ir_in (vji_ir_in),
        .vji_uir   (vji_uir),
        .vji_cdr   (vji_cdr),
        .vji_sdr   (vji_sdr),
        .vji_udr   (vji_udr),
        .vji_rti   (vji_rti)
    );

    // Debug-slave model: a plain shift register clocked by TCK while in SDR.
    logic [SRW-1:0] slave_sr;
    logic           slave_load = 1'b0;
    logic [SRW-1:0] slave_load_val = '0;
    always @(posedge vji_tck or posedge slave_load) begin
        if (slave_load) slave_sr <= slave_load_val;
        else if (vji_sdr) slave_sr <= {vji_tdi, slave_sr[SRW-1:1]};
    end
    assign vji_tdo = slave_sr[0];

    // Record the strobe vector and IR seen at every TCK rise.
    logic [4:0]     rise_q[$];
    logic [IRW-1:0] ir_q[$];
    int rises = 0;
    int sdr_rises = 0;
    always @(posedge vji_tck) begin
        rise_q.push_back({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
        ir_q.push_back(vji_ir_in);
        rises <= rises + 1;
        if (vji_sdr) sdr_rises <= sdr_rises + 1;
    end

    // ---------------- fast DUT (TCK_DIV=1, TDO tied high) ----------------
    nios2_cpu_debug_scan_master_if #(.SR_WIDTH(SRW), .IR_WIDTH(IRW)) fbus();
    logic           f_tck, f_tdi, f_tdo;
    logic [IRW-1:0] f_ir_in;
    logic           f_uir, f_cdr, f_sdr, f_udr, f_rti;
    assign f_tdo = 1'b1;

    nios2_cpu_debug_scan_master #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .TCK_DIV(1)) u_fast (
        .clk       (clk),
        .reset_n   (reset_n),
        .host      (fbus),
        .vji_tck   (f_tck),
        .vji_tdi   (f_tdi),
        .vji_tdo   (f_tdo),
        .vji_ir_in (f_ir_in),
        .vji_uir   (f_uir),
        .vji_cdr   (f_cdr),
        .vji_sdr   (f_sdr),
        .vji_udr   (f_udr),
        .vji_rti   (f_rti)
    );

    logic [SRW-1:0] f_sr = '0;
    logic [IRW-1:0] f_exp_ir = '0;
    int f_rises = 0, f_sdr_rises = 0, f_bad_hot = 0, f_bad_ir = 0;
    always @(posedge f_tck) begin
        f_rises <= f_rises + 1;
        if (f_sdr) begin
            f_sdr_rises <= f_sdr_rises + 1;
            f_sr <= {f_tdi, f_sr[SRW-1:1]};
        end
        if (!$onehot({f_uir, f_cdr, f_sdr, f_udr, f_rti})) f_bad_hot <= f_bad_hot + 1;
        if (f_ir_in !== f_exp_ir) f_bad_ir <= f_bad_ir + 1;
    end

    // ---------------- helpers ----------------
    task automatic preload(input logic [SRW-1:0] val);
        slave_load_val = val;
        slave_load = 1'b1;
        #1;
        slave_load = 1'b0;
    endtask

    // Issue one command on the main DUT and wait for its response.
    task automatic do_scan(input logic [IRW-1:0] ir, input logic [SRW-1:0] data,
                           output logic [SRW-1:0] got, output int lat);
        int  e0;
        bit  done;
        got = '0;
        lat = -1;
        done = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 400 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
        bus.cmd_ir = ir;
        bus.cmd_data = data;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        e0 = cyc;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!done) $display("FAIL scan_done: rsp_valid never seen, required within 1000 cycles");
        else n_pass++;
        if (done) begin
            lat = cyc - e0;
            got = bus.rsp_data;
        end
        $display("scan ir=%b data=%h rsp=%h latency=%0d", ir, data, got, lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_ir = '0; bus.cmd_data = '0;
        fbus.cmd_valid = 1'b0; fbus.cmd_ir = '0; fbus.cmd_data = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL reset_ready: ready=%b busy=%b, required 1/0", bus.cmd_ready, bus.busy);
        else n_pass++;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0) $display("FAIL reset_rsp: valid=%b data=%h, required 0/0", bus.rsp_valid, bus.rsp_data);
        else n_pass++;
        n_checks++;
        if ({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 9'd0)
            $display("FAIL reset_vji: got %b, required 0", {vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
        else n_pass++;
        reset_n = 1'b1;
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic test_single_scan();
        logic [SRW-1:0] got;
        int lat, r0, s0;
        preload(38'h15_A5A5_5A5A);
        r0 = rises; s0 = sdr_rises;
        do_scan(2'b01, 38'h2A_1234_5678, got, lat);
        n_checks++;
        if (got !== 38'h15_A5A5_5A5A) $display("FAIL single_rsp: got %h, required 15a5a55a5a", got);
        else n_pass++;
        n_checks++;
        if (slave_sr !== 38'h2A_1234_5678) $display("FAIL single_slave: got %h, required 2a12345678", slave_sr);
        else n_pass++;
        n_checks++;
        if (lat !== SCAN_CYC) $display("FAIL single_latency: got %0d, required %0d", lat, SCAN_CYC);
        else n_pass++;
        n_checks++;
        if (rises - r0 !== SRW + 4 || sdr_rises - s0 !== SRW)
            $display("FAIL single_tck_rises: total %0d sdr %0d, required %0d/%0d", rises - r0, sdr_rises - s0, SRW + 4, SRW);
        else n_pass++;
    endtask

    task automatic test_strobe_sequence();
        logic [SRW-1:0] got, data;
        logic [4:0] exp_q[$];
        int lat, base;
        int counts[5];
        logic [4:0] codes[5];
        counts = '{1, 1, SRW, 1, 1};
        codes  = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
        for (int p = 0; p < 5; p++)
            for (int k = 0; k < counts[p]; k++) exp_q.push_back(codes[p]);
        data = {$urandom, $urandom};
        preload({$urandom, $urandom});
        base = rise_q.size();
        do_scan(2'b01, data, got, lat);
        n_checks++;
        if (rise_q.size() - base !== exp_q.size()) $display("FAIL strobe_count: got %0d rises, required %0d", rise_q.size() - base, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < rise_q.size(); i++) begin
            n_checks++;
            if (rise_q[base + i] !== exp_q[i]) $display("FAIL strobe_rise%0d: got %b, required %b", i, rise_q[base + i], exp_q[i]);
            else n_pass++;
            n_checks++;
            if (ir_q[base + i] !== 2'b01) $display("FAIL ir_rise%0d: got %b, required 01", i, ir_q[base + i]);
            else n_pass++;
        end
    endtask

    task automatic test_random_scans();
        logic [SRW-1:0] got, data, pre;
        logic [IRW-1:0] ir;
        int lat;
        for (int n = 0; n < 4; n++) begin
            pre  = {$urandom, $urandom};
            data = {$urandom, $urandom};
            ir   = IRW'($urandom_range(0, 3));
            preload(pre);
            do_scan(ir, data, got, lat);
            n_checks++;
            if (got !== pre) $display("FAIL rand%0d_rsp: got %h, required %h", n, got, pre);
            else n_pass++;
            n_checks++;
            if (slave_sr !== data) $display("FAIL rand%0d_slave: got %h, required %h", n, slave_sr, data);
            else n_pass++;
            n_checks++;
            if (lat !== SCAN_CYC) $display("FAIL rand%0d_latency: got %0d, required %0d", n, lat, SCAN_CYC);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [SRW-1:0] pre, a, b, got;
        logic [IRW-1:0] ir_b;
        int e0, e1, early, lat, bad_ir;
        bit done;
        pre = {$urandom, $urandom}; a = {$urandom, $urandom}; b = {$urandom, $urandom};
        ir_b = IRW'($urandom_range(0, 3));
        preload(pre);
        @(negedge clk);
        for (int i = 0; i < 400 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
        bus.cmd_ir = 2'b10; bus.cmd_data = a; bus.cmd_valid = 1'b1;
        @(negedge clk);
        e0 = cyc;
        bus.cmd_ir = ir_b; bus.cmd_data = b;   // second request held while busy
        early = 0; done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                done = 1'b1;
                break;
            end
            if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) early++;
        end
        lat = cyc - e0;
        $display("scan ir=10 data=%h rsp=%h latency=%0d (second request pending)", a, bus.rsp_data, lat);
        n_checks++;
        if (!done || early != 0) $display("FAIL b2b_busy: done=%b ready-early cycles=%0d, required 1/0", done, early);
        else n_pass++;
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || lat !== SCAN_CYC) $display("FAIL b2b_first_end: ready=%b latency=%0d, required 1/%0d", bus.cmd_ready, lat, SCAN_CYC);
        else n_pass++;
        n_checks++;
        if (bus.rsp_data !== pre) $display("FAIL b2b_first_rsp: got %h, required %h", bus.rsp_data, pre);
        else n_pass++;
        // Second command is accepted at the very next edge.
        @(negedge clk);
        e1 = cyc;
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (vji_uir !== 1'b1 || vji_tck !== 1'b0 || bus.busy !== 1'b1) $display("FAIL b2b_accept: uir=%b tck=%b busy=%b, required 1/0/1", vji_uir, vji_tck, bus.busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (vji_tck !== 1'b0) $display("FAIL b2b_tck_low2: got %b, required 0", vji_tck);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (vji_tck !== 1'b1) $display("FAIL b2b_tck_rise: got %b, required 1", vji_tck);
        else n_pass++;
        done = 1'b0; bad_ir = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                done = 1'b1;
                break;
            end
            if (vji_ir_in !== ir_b) bad_ir++;
        end
        got = bus.rsp_data;
        lat = cyc - e1;
        $display("scan ir=%b data=%h rsp=%h latency=%0d", ir_b, b, got, lat);
        n_checks++;
        if (!done || got !== a || lat !== SCAN_CYC) $display("FAIL b2b_second: done=%b rsp=%h latency=%0d, required 1/%h/%0d", done, got, lat, a, SCAN_CYC);
        else n_pass++;
        n_checks++;
        if (bad_ir != 0 || slave_sr !== b) $display("FAIL b2b_second_ir_slave: bad ir cycles=%0d slave=%h, required 0/%h", bad_ir, slave_sr, b);
        else n_pass++;
    endtask

    task automatic test_tck_div1();
        logic [SRW-1:0] data;
        logic [IRW-1:0] ir;
        int e0, lat, r0, s0, h0, i0;
        bit done;
        data = {$urandom, $urandom};
        ir = IRW'($urandom_range(0, 3));
        f_exp_ir = ir;
        r0 = f_rises; s0 = f_sdr_rises; h0 = f_bad_hot; i0 = f_bad_ir;
        @(negedge clk);
        for (int i = 0; i < 400 && fbus.cmd_ready !== 1'b1; i++) @(negedge clk);
        fbus.cmd_ir = ir; fbus.cmd_data = data; fbus.cmd_valid = 1'b1;
        @(negedge clk);
        e0 = cyc;
        fbus.cmd_valid = 1'b0;
        n_checks++;
        if (fbus.busy !== 1'b1 || f_tck !== 1'b0) $display("FAIL fast_accept: busy=%b tck=%b, required 1/0", fbus.busy, f_tck);
        else n_pass++;
        done = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (fbus.rsp_valid === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        lat = cyc - e0;
        $display("fast scan ir=%b data=%h rsp=%h latency=%0d", ir, data, fbus.rsp_data, lat);
        n_checks++;
        if (!done || fbus.rsp_data !== 38'h3F_FFFF_FFFF) $display("FAIL fast_rsp: done=%b got %h, required 3fffffffff", done, fbus.rsp_data);
        else n_pass++;
        n_checks++;
        if (lat !== SCAN_CYC_FAST) $display("FAIL fast_latency: got %0d, required %0d", lat, SCAN_CYC_FAST);
        else n_pass++;
        n_checks++;
        if (f_rises - r0 !== SRW + 4 || f_sdr_rises - s0 !== SRW) $display("FAIL fast_rises: total %0d sdr %0d, required %0d/%0d", f_rises - r0, f_sdr_rises - s0, SRW + 4, SRW);
        else n_pass++;
        n_checks++;
        if (f_sr !== data) $display("FAIL fast_tdi: slave got %h, required %h", f_sr, data);
        else n_pass++;
        n_checks++;
        if (f_bad_hot - h0 != 0 || f_bad_ir - i0 != 0) $display("FAIL fast_strobes: non-onehot %0d bad ir %0d, required 0/0", f_bad_hot - h0, f_bad_ir - i0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        logic [SRW-1:0] pre, data, got;
        int s0, lat, stray;
        bit hit;
        pre = {$urandom, $urandom};
        data = {$urandom, $urandom};
        preload(pre);
        s0 = sdr_rises;
        @(negedge clk);
        for (int i = 0; i < 400 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
        bus.cmd_ir = 2'b11; bus.cmd_data = data; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sdr_rises - s0 >= 10) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit || vji_sdr !== 1'b1) $display("FAIL midreset_reach_sdr: reached=%b sdr=%b, required 1/1", hit, vji_sdr);
        else n_pass++;
        #2;
        reset_n = 1'b0;      // mid clock-low phase: no clk edge until after the check
        #1;
        n_checks++;
        if ({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 9'd0)
            $display("FAIL midreset_vji: got %b, required 0", {vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
        else n_pass++;
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) $display("FAIL midreset_ctrl: ready=%b busy=%b rsp_valid=%b, required 1/0/0", bus.cmd_ready, bus.busy, bus.rsp_valid);
        else n_pass++;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) stray++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 2 * SCAN_CYC; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) stray++;
        end
        $display("reset applied at sdr bit 10, released at cycle %0d", cyc);
        n_checks++;
        if (stray != 0) $display("FAIL midreset_no_rsp: rsp_valid seen %0d cycles, required 0", stray);
        else n_pass++;
        pre = {$urandom, $urandom};
        data = {$urandom, $urandom};
        preload(pre);
        do_scan(2'b10, data, got, lat);
        n_checks++;
        if (got !== pre || lat !== SCAN_CYC) $display("FAIL midreset_fresh: rsp=%h latency=%0d, required %h/%0d", got, lat, pre, SCAN_CYC);
        else n_pass++;
        n_checks++;
        if (slave_sr !== data) $display("FAIL midreset_fresh_slave: got %h, required %h", slave_sr, data);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_strobe_sequence();
        test_random_scans();
        test_back_to_back();
        test_tck_div1();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
